// File: rtl/program_store.sv
// program_store
//   Writable instruction store for the Hovalaag CPU fetch path. The CPU reads
//   through a registered port; a byte-serial loader writes new program images
//   at run time, with a valid/ready handshake.
//
// Optional build macro: PROGRAM_CHECKSUM_EN
//   When defined, adds output load_sum, the modulo-2^DATA_W sum of the words
//   actually written during the current load.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   addr        CPU fetch address
//   data        registered instruction word (1-cycle latency)
//   load_start  begin a load (honoured in IDLE only)
//   load_base   first word address, latched on load_start
//   load_len    word count minus 1, latched on load_start
//   load_byte   loader data byte, MSB-first within a word
//   load_valid  load_byte is valid
//   load_ready  block accepts a byte this cycle
//   loading     high while a load is in progress
//   load_done   one-cycle pulse when the last word has been handled
//   load_err    sticky: a word targeted an address >= DEPTH and was dropped
//   load_sum    (PROGRAM_CHECKSUM_EN only) sum of written words
module program_store #(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 256,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(32'h00008000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              loading,
  output logic              load_done,
  output logic              load_err
`ifdef PROGRAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_sum
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    byte_cnt_reg;
  logic [ADDR_W-1:0]   words_left_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                load_ready_reg;
  logic                loading_reg;
  logic                load_done_reg;
  logic                load_err_reg;
  logic [DATA_W-1:0]   load_sum_reg;

  // Image memory. Not touched by reset: only the configuration image sets it.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: DEFAULT_WORD};

  logic              accept;
  logic              word_done;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              mem_we;
  logic              load_next;
  logic [DATA_W-1:0] asm_word;

  // A byte arriving on a reset edge is not taken, so a reset always discards
  // the partial word cleanly.
  assign accept      = rst_n && load_valid && load_ready_reg;
  assign word_done   = accept && (byte_cnt_reg == LAST_BYTE);
  assign wr_in_range = {1'b0, wr_addr_reg} < DEPTH_L;
  assign rd_in_range = {1'b0, addr} < DEPTH_L;
  assign mem_we      = word_done && wr_in_range;

  // Shift-in word: earlier bytes move up, newest byte lands in the low lane,
  // so after BYTES shifts the first byte sits in the top lane.
  assign asm_word = (shift_reg << 8) | DATA_W'(load_byte);

  // True when the FSM will be in LOAD after this edge. The read register uses
  // it so data shows DEFAULT_WORD on every cycle where loading is high.
  assign load_next = (state_reg == IDLE && load_start) ||
                     (state_reg == LOAD && !(word_done && words_left_reg == '0));

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_reg[IDX_W-1:0]] <= asm_word;
    end
  end

  // Registered read; a write on the same edge returns the old contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg <= DEFAULT_WORD;
    end else if (load_next || !rd_in_range) begin
      data_reg <= DEFAULT_WORD;
    end else begin
      data_reg <= mem[addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      byte_cnt_reg   <= '0;
      words_left_reg <= '0;
      wr_addr_reg    <= '0;
      shift_reg      <= '0;
      load_ready_reg <= 1'b0;
      loading_reg    <= 1'b0;
      load_done_reg  <= 1'b0;
      load_err_reg   <= 1'b0;
      load_sum_reg   <= '0;
    end else begin
      load_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            wr_addr_reg    <= load_base;
            words_left_reg <= load_len;
            byte_cnt_reg   <= '0;
            load_err_reg   <= 1'b0;
            load_sum_reg   <= '0;
            load_ready_reg <= 1'b1;
            loading_reg    <= 1'b1;
            state_reg      <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            shift_reg <= asm_word;
            if (byte_cnt_reg == LAST_BYTE) begin
              byte_cnt_reg <= '0;
              wr_addr_reg  <= wr_addr_reg + ADDR_W'(1);
              // Dropped words still count toward the length.
              if (!wr_in_range) begin
                load_err_reg <= 1'b1;
              end else begin
                load_sum_reg <= load_sum_reg + asm_word;
              end
              if (words_left_reg == '0) begin
                load_ready_reg <= 1'b0;
                loading_reg    <= 1'b0;
                load_done_reg  <= 1'b1;
                state_reg      <= DONE;
              end else begin
                words_left_reg <= words_left_reg - ADDR_W'(1);
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign data       = data_reg;
  assign load_ready = load_ready_reg;
  assign loading    = loading_reg;
  assign load_done  = load_done_reg;
  assign load_err   = load_err_reg;

`ifdef PROGRAM_CHECKSUM_EN
  assign load_sum = load_sum_reg;
`else
  // Without the checksum output the running sum has no consumer.
  logic unused_sum;
  assign unused_sum = ^load_sum_reg;
`endif

endmodule

// File: tb/tb_program_store.sv
module tb_program_store;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam logic [31:0] DEF = 32'h00008000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] data;
  logic        load_start = 1'b0;
  logic [7:0]  load_base = '0;
  logic [7:0]  load_len = '0;
  logic [7:0]  load_byte = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        loading;
  logic        load_done;
  logic        load_err;
`ifdef PROGRAM_CHECKSUM_EN
  logic [31:0] load_sum;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the full 2^ADDR_W word space, where addresses >= DEPTH
  // simply never get written and so always read back the NOP word.
  logic [31:0] model_mem [256];
  logic        model_err;
  logic [31:0] model_sum;
  logic [31:0] wbuf [16];

  program_store #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DEFAULT_WORD(DEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data(data),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_byte(load_byte), .load_valid(load_valid), .load_ready(load_ready),
    .loading(loading), .load_done(load_done), .load_err(load_err)
`ifdef PROGRAM_CHECKSUM_EN
    , .load_sum(load_sum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input logic [7:0] a);
    addr = a;
    tick();
    check("read", data, model_mem[a]);
    $display("read  addr=%02h data=%08h exp=%08h", a, data, model_mem[a]);
  endtask

  // gap_mode: 0 back-to-back, 1 valid toggles every other cycle, 2 random gaps.
  // abort_at: byte index at which reset is asserted instead (-1 = never).
  task automatic run_load(input logic [7:0] base, input logic [7:0] len,
                          input int gap_mode, input int abort_at);
    int nbytes;
    int k;
    logic [31:0] word;
    logic [7:0]  wa;
    nbytes = (int'(len) + 1) * 4;
    model_err = 1'b0;
    model_sum = '0;
    // Start cycle also presents a valid byte: it must not be taken.
    load_start = 1'b1; load_base = base; load_len = len;
    load_valid = 1'b1; load_byte = 8'hFF; addr = 8'($urandom);
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    check("ready_in_load", {31'b0, load_ready}, 32'd1);
    check("loading_in_load", {31'b0, loading}, 32'd1);
    check("data_default_start", data, DEF);
    for (int b = 0; b < nbytes; b++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        load_valid = 1'b0; load_byte = 8'($urandom);
        load_start = 1'b1; load_base = 8'($urandom); load_len = 8'($urandom);
        addr = 8'($urandom);
        tick();
        load_start = 1'b0;
        check("loading_gap", {31'b0, loading}, 32'd1);
        check("data_default_gap", data, DEF);
        check("done_gap", {31'b0, load_done}, 32'd0);
      end
      k = b / 4;
      word = wbuf[k];
      if (abort_at == b) begin
        rst_n = 1'b0; load_valid = 1'b1; load_byte = word[8*(3-(b%4)) +: 8];
        tick();
        rst_n = 1'b1; load_valid = 1'b0;
        tick();
        check("abort_loading", {31'b0, loading}, 32'd0);
        check("abort_ready", {31'b0, load_ready}, 32'd0);
        check("abort_done", {31'b0, load_done}, 32'd0);
        check("abort_err", {31'b0, load_err}, 32'd0);
        $display("load  base=%02h len=%0d aborted after %0d bytes", base, len, b);
        return;
      end
      load_valid = 1'b1;
      load_byte = word[8*(3-(b%4)) +: 8];
      addr = 8'($urandom);
      tick();
      if (b % 4 == 3) begin
        wa = base + 8'(k);
        if (int'(wa) < DEPTH) begin
          model_mem[wa] = word;
          model_sum = model_sum + word;
        end else begin
          model_err = 1'b1;
        end
      end
      if (b != nbytes - 1) begin
        check("loading_mid", {31'b0, loading}, 32'd1);
        check("data_default_mid", data, DEF);
        check("done_mid", {31'b0, load_done}, 32'd0);
      end
    end
    load_valid = 1'b0;
    check("done_pulse", {31'b0, load_done}, 32'd1);
    check("loading_done", {31'b0, loading}, 32'd0);
    check("ready_done", {31'b0, load_ready}, 32'd0);
    check("err_done", {31'b0, load_err}, {31'b0, model_err});
`ifdef PROGRAM_CHECKSUM_EN
    check("sum_done", load_sum, model_sum);
`endif
    tick();
    check("done_one_cycle", {31'b0, load_done}, 32'd0);
    check("err_sticky", {31'b0, load_err}, {31'b0, model_err});
`ifdef PROGRAM_CHECKSUM_EN
    check("sum_stable", load_sum, model_sum);
`endif
    $display("load  base=%02h len=%0d gaps=%0d err=%0b", base, len, gap_mode, model_err);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = DEF;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_data", data, DEF);
    check("rst_ready", {31'b0, load_ready}, 32'd0);
    check("rst_loading", {31'b0, loading}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_err", {31'b0, load_err}, 32'd0);
    read_check(8'h05);

    // Directed two-word load, back-to-back
    wbuf[0] = 32'h0300219F;
    wbuf[1] = 32'h2340100A;
    run_load(8'h00, 8'd1, 0, -1);
`ifdef PROGRAM_CHECKSUM_EN
    check("tp_sum", model_sum, 32'h264031A9);
`endif
    read_check(8'h00);
    check("tp_word0", data, 32'h0300219F);
    read_check(8'h01);
    check("tp_word1", data, 32'h2340100A);

    // Same load with valid toggling
    run_load(8'h00, 8'd1, 1, -1);
    read_check(8'h00);
    read_check(8'h01);

    // Straddle the end of the implemented range
    wbuf[0] = 32'hA5A5_1234;
    wbuf[1] = 32'h5A5A_4321;
    run_load(8'h0F, 8'd1, 0, -1);
    check("oor_err", {31'b0, load_err}, 32'd1);
    read_check(8'h0F);
    read_check(8'h10);
    check("oor_read", data, DEF);

    // Reset after 5 bytes of a two-word load
    wbuf[0] = 32'hDEAD_BEEF;
    wbuf[1] = 32'hCAFE_F00D;
    run_load(8'h02, 8'd1, 0, 5);
    read_check(8'h02);
    read_check(8'h03);
    check("abort_ready_idle", {31'b0, load_ready}, 32'd0);

    // Wrap past the top of the address space
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    run_load(8'hFF, 8'd2, 2, -1);
    read_check(8'h00);
    read_check(8'h01);

    // Randomised loads and reads
    for (int t = 0; t < 15; t++) begin
      logic [7:0] base;
      logic [7:0] len;
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      base = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      len  = 8'($urandom_range(0, 4));
      run_load(base, len, int'($urandom_range(0, 2)), -1);
      for (int r = 0; r < 6; r++) begin
        read_check(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
